ncl_dr_ripple_adder_sync: RTL and testbench
===========================================

// Module: ncl_dr_ripple_adder_sync
// PURPOSE
//  WIDTH-bit dual-rail (NCL-encoded) adder with DATA/NULL wavefront handshake, evaluated
//  serially BPC bits per clock. Generalises the single-bit dual-rail full adder cell to N bits.
//  Adds operand capture, an explicit handshake FSM and illegal-code detection.
//  Sits between dual-rail register stages in clocked NCL emulation/prototyping flows.
// PARAMETERS
//  WIDTH  4  operand width in bits; each bit is carried on 2 rails
//  BPC    1  bits resolved per RIPPLE cycle; must divide WIDTH (checked at elaboration)
// PORTS
//  clk       in   1          system clock, all state updates on posedge
//  init_n    in   1          synchronous active-low reset
//  a         in   2*WIDTH    operand A; bit i = a[2i+1:2i]: [2i]=rail0 (false), [2i+1]=rail1 (true)
//  b         in   2*WIDTH    operand B, same encoding
//  cin       in   2          carry-in, same encoding
//  ko_in     in   1          downstream completion: 1 = downstream holds DATA (request NULL), 0 = request DATA
//  sum       out  2*WIDTH    dual-rail sum, same encoding
//  cout      out  2          dual-rail carry-out
//  comp_out  out  1          completion to upstream: 1 = outputs hold complete DATA, 0 = outputs NULL
//  err       out  1          sticky: illegal code (rails 11) seen on an input while in WAIT_DATA
// BEHAVIOUR
//  Encoding per bit: 00 NULL, 01 DATA-0, 10 DATA-1, 11 illegal. Inputs "complete DATA" = every
//   pair of a,b,cin one-hot; "all NULL" = every rail 0.
//  Reset (init_n=0 at posedge): state WAIT_DATA, sum=0, cout=0, comp_out=0, err=0, bit index 0.
//  FSM WAIT_DATA: outputs NULL. If ko_in=0 and inputs complete DATA and no pair is 11:
//   capture a,b,cin into internal regs, index=0, -> RIPPLE. Partial DATA: stay, no capture.
//   Any pair 11: err<=1 (sticky until reset), no capture, stay. ko_in=1: stay, no capture.
//  RIPPLE: each cycle resolves bits [index+BPC-1:index] from captured operands and the internal
//   dual-rail carry (s = a^b^c, c' = maj(a,b,c), per-bit rails one-hot); index += BPC.
//   Live inputs and ko_in are ignored here. After the cycle resolving bit WIDTH-1: next edge
//   loads sum, cout with full result, comp_out<=1 together, -> HOLD_DATA. No partial result is
//   ever visible on sum/cout (all-NULL until the single transition to DATA).
//  Latency: inputs captured at edge E; sum/cout/comp_out DATA after edge E+WIDTH/BPC.
//  HOLD_DATA: outputs stable DATA. When ko_in=1 AND inputs all NULL at the same edge:
//   sum<=0, cout<=0, comp_out<=0, -> WAIT_DATA. Either condition alone: hold.
//   Illegal codes here do not set err.
//  Minimum DATA->DATA cycle: capture, WIDTH/BPC ripple edges, >=1 hold, 1 NULL edge.
//  Carry wrap: cout reports the carry out of bit WIDTH-1; sum is the result modulo 2^WIDTH.
//  Reset mid-RIPPLE or HOLD_DATA: outputs NULL, comp_out=0, captured operands discarded,
//   err cleared; a new DATA wave is needed (inputs held complete DATA re-capture once ko_in=0).
//  sum/cout are registered; no combinational path from inputs to outputs.
//  err does not block operation.
// TESTING (WIDTH=4, BPC=1 unless noted)
//  A=0x9 (8'b10_01_01_10), B=0x7 (8'b01_10_10_10), cin=1 (2'b10), ko_in=0 -> 4 edges after
//   capture: sum=8'b01_01_01_10 (0x1), cout=2'b10, comp_out=1; hold until ko_in=1 + inputs
//   NULL, then one edge later sum=0, cout=0, comp_out=0.
//  A=0xF, B=0x0, cin=0 -> sum=8'b10_10_10_10 (0xF), cout=2'b01; BPC=2 variant: same result
//   after 2 edges.
//  Inputs complete DATA but ko_in=1 for 5 cycles -> no capture, outputs NULL; capture on the
//   first edge with ko_in=0.
//  a[1:0]=2'b11, other inputs complete DATA -> err=1 next edge, no capture; err remains 1 after
//   inputs legalise and the add completes.
//  Reset asserted on 2nd RIPPLE cycle -> next edge all outputs 0, state WAIT_DATA; inputs still
//   DATA with ko_in=0 -> fresh capture and correct result 4 edges later.
//  HOLD_DATA with ko_in=1 but b[3:2] still DATA -> outputs held DATA until b fully NULL.

Source files
------------

// File: rtl/ncl_dr_ripple_adder_sync.sv
// rtl/ncl_dr_ripple_adder_sync.sv - dual-rail NCL ripple adder resolving BPC bits per clock
module ncl_dr_ripple_adder_sync #(
    parameter int WIDTH = 4,
    parameter int BPC   = 1
) (
    input  logic               clk,
    input  logic               init_n,
    input  logic [2*WIDTH-1:0] a,
    input  logic [2*WIDTH-1:0] b,
    input  logic [1:0]         cin,
    input  logic               ko_in,
    output logic [2*WIDTH-1:0] sum,
    output logic [1:0]         cout,
    output logic               comp_out,
    output logic               err
);

    localparam int IW = $clog2(WIDTH + 1);

    if (BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_bpc
        $error("BPC must be >= 1 and divide WIDTH");
    end

    typedef enum logic [1:0] {
        WAIT_DATA,
        RIPPLE,
        HOLD_DATA
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, a_t, b_t;
    logic [1:0]         carry_q, carry_next;
    logic [2*WIDTH-1:0] acc_q, acc_next;
    logic [IW-1:0]      idx_q;
    logic               in_complete, in_illegal, in_null;
    logic               capture, last_step, release_wave;
    logic               c, s;

    // Classify the live input wavefront and pull the true rail as the bit value.
    always_comb begin
        in_complete = cin[0] ^ cin[1];
        in_illegal  = &cin;
        in_null     = ~|cin;
        a_t         = '0;
        b_t         = '0;
        for (int i = 0; i < WIDTH; i++) begin
            in_complete = in_complete & (a[2*i] ^ a[2*i+1]) & (b[2*i] ^ b[2*i+1]);
            in_illegal  = in_illegal | (&a[2*i +: 2]) | (&b[2*i +: 2]);
            a_t[i]      = a[2*i+1];
            b_t[i]      = b[2*i+1];
        end
        in_null = in_null & ~|a & ~|b;
    end

    // Resolve the BPC-bit window starting at idx_q; carry enters from the stored dual-rail carry.
    always_comb begin
        acc_next = acc_q;
        c        = carry_q[1] & ~carry_q[0];
        s        = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            if (k >= int'(idx_q) && k < int'(idx_q) + BPC) begin
                s = a_q[k] ^ b_q[k] ^ c;
                c = (a_q[k] & b_q[k]) | (a_q[k] & c) | (b_q[k] & c);
                acc_next[2*k +: 2] = {s, ~s};
            end
        end
        carry_next = {c, ~c};
    end

    assign capture      = (state_q == WAIT_DATA) && !ko_in && in_complete;
    assign last_step    = (idx_q == IW'(WIDTH - BPC));
    assign release_wave = ko_in && in_null;

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_DATA: if (capture) state_d = RIPPLE;
            RIPPLE:    if (last_step) state_d = HOLD_DATA;
            HOLD_DATA: if (release_wave) state_d = WAIT_DATA;
            default:   state_d = WAIT_DATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!init_n) begin
            state_q  <= WAIT_DATA;
            sum      <= '0;
            cout     <= '0;
            comp_out <= 1'b0;
            err      <= 1'b0;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= '0;
            acc_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                WAIT_DATA: begin
                    if (in_illegal) err <= 1'b1;
                    if (capture) begin
                        a_q     <= a_t;
                        b_q     <= b_t;
                        carry_q <= cin;
                        acc_q   <= '0;
                        idx_q   <= '0;
                    end
                end
                RIPPLE: begin
                    acc_q   <= acc_next;
                    carry_q <= carry_next;
                    idx_q   <= idx_q + IW'(BPC);
                    // Outputs jump straight from NULL to the complete result.
                    if (last_step) begin
                        sum      <= acc_next;
                        cout     <= carry_next;
                        comp_out <= 1'b1;
                    end
                end
                HOLD_DATA: begin
                    if (release_wave) begin
                        sum      <= '0;
                        cout     <= '0;
                        comp_out <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ncl_dr_ripple_adder_sync.sv
// tb/tb_ncl_dr_ripple_adder_sync.sv - randomized self-checking bench against an arithmetic model
module tb_ncl_dr_ripple_adder_sync;

    logic       clk = 1'b0;
    logic       init_n;
    logic [7:0] a, b;
    logic [1:0] cin;
    logic       ko_in;
    logic [7:0] sum, sum2;
    logic [1:0] cout, cout2;
    logic       comp_out, comp_out2, err, err2;

    int errors = 0;
    int checks = 0;

    ncl_dr_ripple_adder_sync #(.WIDTH(4), .BPC(1)) dut (
        .clk(clk), .init_n(init_n), .a(a), .b(b), .cin(cin), .ko_in(ko_in),
        .sum(sum), .cout(cout), .comp_out(comp_out), .err(err)
    );

    ncl_dr_ripple_adder_sync #(.WIDTH(4), .BPC(2)) dut2 (
        .clk(clk), .init_n(init_n), .a(a), .b(b), .cin(cin), .ko_in(ko_in),
        .sum(sum2), .cout(cout2), .comp_out(comp_out2), .err(err2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] enc4(input logic [3:0] v);
        logic [7:0] r;
        for (int i = 0; i < 4; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
        return r;
    endfunction

    function automatic logic [1:0] enc1(input logic v);
        return v ? 2'b10 : 2'b01;
    endfunction

    // Presents a DATA wave, lets it be captured, and records what both DUTs show.
    task automatic run_add(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                           output logic early, output logic [7:0] s1, output logic [1:0] c1,
                           output logic k1, output logic [7:0] s2, output logic [1:0] c2,
                           output logic k2);
        a = enc4(av); b = enc4(bv); cin = enc1(cv); ko_in = 1'b0;
        early = 1'b0;
        s2 = '0; c2 = '0; k2 = 1'b0;
        tick();
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 2) begin s2 = sum2; c2 = cout2; k2 = comp_out2; end
            if (k < 4) early = early | comp_out | (|sum) | (|cout);
        end
        s1 = sum; c1 = cout; k1 = comp_out;
    endtask

    task automatic null_wave();
        a = '0; b = '0; cin = '0; ko_in = 1'b1;
        tick();
        ko_in = 1'b0;
    endtask

    task automatic test_reset();
        init_n = 1'b0; a = '0; b = '0; cin = '0; ko_in = 1'b0;
        tick(); tick();
        checks++;
        if ({sum, cout, comp_out, err} !== 12'h0) begin
            errors++;
            $display("FAIL reset_outputs: got sum=%b cout=%b comp=%b err=%b want all 0", sum, cout, comp_out, err);
        end
        init_n = 1'b1;
        tick();
    endtask

    task automatic test_spec_vector();
        logic e, k1, k2; logic [7:0] s1, s2; logic [1:0] c1, c2;
        run_add(4'h9, 4'h7, 1'b1, e, s1, c1, k1, s2, c2, k2);
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL vec_no_partial: early=%b want 0", e); end
        checks++;
        if ({s1, c1, k1} !== {8'b01_01_01_10, 2'b10, 1'b1}) begin
            errors++;
            $display("FAIL vec_result: got sum=%b cout=%b comp=%b want 01010110 10 1", s1, c1, k1);
        end
        a = '0; b = '0; cin = '0; ko_in = 1'b0;
        tick(); tick();
        checks++;
        if ({sum, cout, comp_out} !== {8'b01_01_01_10, 2'b10, 1'b1}) begin
            errors++; $display("FAIL hold_null_only: got sum=%b comp=%b want held DATA", sum, comp_out);
        end
        a = enc4(4'h9); b = enc4(4'h7); cin = 2'b10; ko_in = 1'b1;
        tick(); tick();
        checks++;
        if ({sum, cout, comp_out} !== {8'b01_01_01_10, 2'b10, 1'b1}) begin
            errors++; $display("FAIL hold_ko_only: got sum=%b comp=%b want held DATA", sum, comp_out);
        end
        null_wave();
        checks++;
        if ({sum, cout, comp_out} !== 11'h0) begin
            errors++; $display("FAIL vec_release: got sum=%b cout=%b comp=%b want 0", sum, cout, comp_out);
        end
    endtask

    task automatic test_bpc2();
        logic e, k1, k2; logic [7:0] s1, s2; logic [1:0] c1, c2;
        run_add(4'hF, 4'h0, 1'b0, e, s1, c1, k1, s2, c2, k2);
        checks++;
        if ({s2, c2, k2} !== {8'b10_10_10_10, 2'b01, 1'b1}) begin
            errors++; $display("FAIL bpc2_result: got sum=%b cout=%b comp=%b want 10101010 01 1", s2, c2, k2);
        end
        checks++;
        if ({s1, c1, k1, e} !== {8'b10_10_10_10, 2'b01, 1'b1, 1'b0}) begin
            errors++; $display("FAIL bpc1_f_plus_0: got sum=%b cout=%b comp=%b early=%b", s1, c1, k1, e);
        end
        null_wave();
    endtask

    task automatic test_ko_block();
        logic e, k1, k2; logic [7:0] s1, s2; logic [1:0] c1, c2;
        logic seen;
        seen = 1'b0;
        a = enc4(4'h3); b = enc4(4'h6); cin = 2'b01; ko_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen = seen | comp_out | (|sum) | comp_out2;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL ko_block: outputs went DATA while ko_in=1, want NULL"); end
        run_add(4'h3, 4'h6, 1'b0, e, s1, c1, k1, s2, c2, k2);
        checks++;
        if ({s1, c1, k1} !== {enc4(4'h9), 2'b01, 1'b1}) begin
            errors++; $display("FAIL ko_release_capture: got sum=%b cout=%b comp=%b want %b 01 1", s1, c1, k1, enc4(4'h9));
        end
        null_wave();
    endtask

    task automatic test_illegal();
        logic e, k1, k2; logic [7:0] s1, s2; logic [1:0] c1, c2;
        logic seen;
        seen = 1'b0;
        a = {enc4(4'h4)[7:2], 2'b11}; b = enc4(4'h2); cin = 2'b01; ko_in = 1'b0;
        tick();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL illegal_err: got err=%b want 1", err); end
        for (int i = 0; i < 5; i++) begin
            tick();
            seen = seen | comp_out | (|sum);
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL illegal_no_capture: outputs went DATA, want NULL"); end
        run_add(4'h4, 4'h2, 1'b0, e, s1, c1, k1, s2, c2, k2);
        checks++;
        if ({s1, c1, k1, err} !== {enc4(4'h6), 2'b01, 1'b1, 1'b1}) begin
            errors++; $display("FAIL illegal_sticky: got sum=%b cout=%b comp=%b err=%b want %b 01 1 1", s1, c1, k1, err, enc4(4'h6));
        end
        null_wave();
    endtask

    task automatic test_reset_mid();
        logic e, k1, k2; logic [7:0] s1, s2; logic [1:0] c1, c2;
        a = enc4(4'hB); b = enc4(4'h6); cin = 2'b10; ko_in = 1'b0;
        tick(); tick();
        init_n = 1'b0;
        tick();
        checks++;
        if ({sum, cout, comp_out, err, comp_out2} !== 13'h0) begin
            errors++; $display("FAIL reset_mid: got sum=%b cout=%b comp=%b err=%b want all 0", sum, cout, comp_out, err);
        end
        init_n = 1'b1;
        run_add(4'hB, 4'h6, 1'b1, e, s1, c1, k1, s2, c2, k2);
        checks++;
        if ({s1, c1, k1, e} !== {enc4(4'h2), 2'b10, 1'b1, 1'b0}) begin
            errors++; $display("FAIL reset_mid_recapture: got sum=%b cout=%b comp=%b early=%b want %b 10 1 0", s1, c1, k1, e, enc4(4'h2));
        end
        null_wave();
    endtask

    task automatic test_hold_partial();
        logic e, k1, k2; logic [7:0] s1, s2; logic [1:0] c1, c2;
        logic held;
        run_add(4'h5, 4'h5, 1'b0, e, s1, c1, k1, s2, c2, k2);
        held = 1'b1;
        a = '0; cin = '0; b = 8'b00_00_01_00; ko_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            held = held & comp_out & (sum === enc4(4'hA)) & (cout === 2'b01);
        end
        checks++;
        if (held !== 1'b1) begin errors++; $display("FAIL hold_partial_null: got sum=%b comp=%b want %b 1", sum, comp_out, enc4(4'hA)); end
        b = '0;
        tick();
        checks++;
        if ({sum, cout, comp_out} !== 11'h0) begin
            errors++; $display("FAIL hold_partial_release: got sum=%b comp=%b want 0", sum, comp_out);
        end
        ko_in = 1'b0;
    endtask

    task automatic test_random();
        logic e, k1, k2; logic [7:0] s1, s2; logic [1:0] c1, c2;
        logic [3:0] av, bv; logic cv; logic [4:0] r;
        for (int n = 0; n < 25; n++) begin
            av = 4'($urandom_range(0, 15));
            bv = 4'($urandom_range(0, 15));
            cv = 1'($urandom_range(0, 1));
            r  = 5'(av) + 5'(bv) + 5'(cv);
            run_add(av, bv, cv, e, s1, c1, k1, s2, c2, k2);
            checks++;
            if ({s1, c1, k1, e} !== {enc4(r[3:0]), enc1(r[4]), 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL random_bpc1: %h+%h+%b got sum=%b cout=%b comp=%b early=%b want %b %b", av, bv, cv, s1, c1, k1, e, enc4(r[3:0]), enc1(r[4]));
            end
            checks++;
            if ({s2, c2, k2} !== {enc4(r[3:0]), enc1(r[4]), 1'b1}) begin
                errors++;
                $display("FAIL random_bpc2: %h+%h+%b got sum=%b cout=%b comp=%b want %b %b", av, bv, cv, s2, c2, k2, enc4(r[3:0]), enc1(r[4]));
            end
            null_wave();
            checks++;
            if ({sum, cout, comp_out, sum2, comp_out2} !== 20'h0) begin
                errors++; $display("FAIL random_release: got sum=%b comp=%b sum2=%b want 0", sum, comp_out, sum2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_spec_vector();
        test_bpc2();
        test_ko_block();
        test_illegal();
        test_reset_mid();
        test_hold_partial();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
